// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode->execute pipeline register.
// Holds operands, register numbers, immediate, PC pair and the packed control
// word for one cycle, with valid tracking, stall (hold), flush (bubble insert)
// and a saturating count of inserted bubbles.
// Optional feature macro: ID_WB_BYPASS_EN adds the wb_* ports and forwards
// write-back data into the source operand slots, both while capturing from
// decode and while the stage is held by a stall.
module id_ex_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int NUM_SRC = 2,
    parameter int CTRL_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [XLEN-1:0]           id_pc,
    input  logic [XLEN-1:0]           id_pc_plus_4,
    input  logic [NUM_SRC*RA_W-1:0]   id_rs_num,
    input  logic [NUM_SRC*XLEN-1:0]   id_rs_val,
    input  logic [RA_W-1:0]           id_rd_num,
    input  logic [XLEN-1:0]           id_imm,
    input  logic [CTRL_W-1:0]         id_ctrl,
    output logic                      ex_valid,
    output logic [XLEN-1:0]           ex_pc,
    output logic [XLEN-1:0]           ex_pc_plus_4,
    output logic [NUM_SRC*RA_W-1:0]   ex_rs_num,
    output logic [NUM_SRC*XLEN-1:0]   ex_rs_val,
    output logic [RA_W-1:0]           ex_rd_num,
    output logic [XLEN-1:0]           ex_imm,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [CNT_W-1:0]          bubble_cnt
`ifdef ID_WB_BYPASS_EN
    ,
    input  logic                      wb_we,
    input  logic [RA_W-1:0]           wb_rd_num,
    input  logic [XLEN-1:0]           wb_data
`endif
);

    // Stage registers
    logic                      valid_q,  valid_d;
    logic [XLEN-1:0]           pc_q,     pc_d;
    logic [XLEN-1:0]           pc4_q,    pc4_d;
    logic [NUM_SRC*RA_W-1:0]   rs_num_q, rs_num_d;
    logic [NUM_SRC*XLEN-1:0]   rs_val_q, rs_val_d;
    logic [RA_W-1:0]           rd_q,     rd_d;
    logic [XLEN-1:0]           imm_q,    imm_d;
    logic [CTRL_W-1:0]         ctrl_q,   ctrl_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;

    // Per-cycle action after priority resolution (reset handled in the flop).
    logic do_load;
    logic do_hold;
    logic bubble;

    // Bypass match per source channel, against decode and against the held slot.
    logic [NUM_SRC-1:0] id_match;
    logic [NUM_SRC-1:0] ex_match;
    logic [XLEN-1:0]    byp_data;

    assign id_ready = ~stall;

    // Flush beats stall; load happens only when neither is asserted.
    assign do_hold = stall & ~flush;
    assign do_load = ~stall & ~flush;
    // A bubble is any cycle where the valid bit is written to zero.
    assign bubble  = flush | (do_load & ~id_valid);

`ifdef ID_WB_BYPASS_EN
    assign byp_data = wb_data;
    genvar gi;
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_match
        // Register 0 is hardwired zero, so a write to it is never forwarded.
        assign id_match[gi] = wb_we && (wb_rd_num != '0) &&
                              (wb_rd_num == id_rs_num[gi*RA_W +: RA_W]);
        assign ex_match[gi] = wb_we && (wb_rd_num != '0) &&
                              (wb_rd_num == rs_num_q[gi*RA_W +: RA_W]);
    end
`else
    assign byp_data = '0;
    assign id_match = '0;
    assign ex_match = '0;
`endif

    // Control/valid side: kill ctrl and rd on any bubble so the invariant
    // "invalid slot has no side effects" holds by construction.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            rd_d    = '0;
            ctrl_d  = '0;
        end else if (do_load) begin
            valid_d = id_valid;
            rd_d    = id_valid ? id_rd_num : '0;
            ctrl_d  = id_valid ? id_ctrl   : '0;
        end
    end

    // Data side: captured on every load (even bubbles), held on stall/flush.
    always_comb begin
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        rs_num_d = rs_num_q;
        imm_d    = imm_q;
        if (do_load) begin
            pc_d     = id_pc;
            pc4_d    = id_pc_plus_4;
            rs_num_d = id_rs_num;
            imm_d    = id_imm;
        end
    end

    // Source operand values, per channel: capture with optional forward on
    // load; while held with a live instruction, a matching write-back refreshes
    // the stale operand so the instruction sees it when the stall releases.
    always_comb begin
        rs_val_d = rs_val_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (do_load) begin
                rs_val_d[i*XLEN +: XLEN] = id_match[i] ? byp_data
                                                       : id_rs_val[i*XLEN +: XLEN];
            end else if (do_hold && valid_q && ex_match[i]) begin
                rs_val_d[i*XLEN +: XLEN] = byp_data;
            end
        end
    end

    // Saturating bubble counter; stalls never count.
    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register; synchronous reset clears every output-visible field.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            pc4_q    <= '0;
            rs_num_q <= '0;
            rs_val_q <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            rs_num_q <= rs_num_d;
            rs_val_q <= rs_val_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_pc_plus_4 = pc4_q;
    assign ex_rs_num    = rs_num_q;
    assign ex_rs_val    = rs_val_q;
    assign ex_rd_num    = rd_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg. A second instance with a 2-bit
// bubble counter shares all inputs to exercise saturation.
module tb_id_ex_pipe_reg;

    localparam int XLEN    = 32;
    localparam int RA_W    = 5;
    localparam int NUM_SRC = 2;
    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 16;
    localparam int VW      = 1 + 3*XLEN + NUM_SRC*(RA_W+XLEN) + RA_W + CTRL_W + CNT_W;

    logic                    clk = 1'b0;
    logic                    reset, stall, flush, id_valid;
    logic                    id_ready, id_ready_s;
    logic [XLEN-1:0]         id_pc, id_pc_plus_4, id_imm;
    logic [NUM_SRC*RA_W-1:0] id_rs_num;
    logic [NUM_SRC*XLEN-1:0] id_rs_val;
    logic [RA_W-1:0]         id_rd_num;
    logic [CTRL_W-1:0]       id_ctrl;
    logic                    ex_valid, ex_valid_s;
    logic [XLEN-1:0]         ex_pc, ex_pc_plus_4, ex_imm;
    logic [XLEN-1:0]         ex_pc_s, ex_pc_plus_4_s, ex_imm_s;
    logic [NUM_SRC*RA_W-1:0] ex_rs_num, ex_rs_num_s;
    logic [NUM_SRC*XLEN-1:0] ex_rs_val, ex_rs_val_s;
    logic [RA_W-1:0]         ex_rd_num, ex_rd_num_s;
    logic [CTRL_W-1:0]       ex_ctrl, ex_ctrl_s;
    logic [CNT_W-1:0]        bubble_cnt;
    logic [1:0]              bubble_cnt_s;
`ifdef ID_WB_BYPASS_EN
    logic                    wb_we;
    logic [RA_W-1:0]         wb_rd_num;
    logic [XLEN-1:0]         wb_data;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .NUM_SRC(NUM_SRC), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
        .id_rs_num(id_rs_num), .id_rs_val(id_rs_val), .id_rd_num(id_rd_num),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_rs_num(ex_rs_num), .ex_rs_val(ex_rs_val),
        .ex_rd_num(ex_rd_num), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
`ifdef ID_WB_BYPASS_EN
        , .wb_we(wb_we), .wb_rd_num(wb_rd_num), .wb_data(wb_data)
`endif
    );

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .NUM_SRC(NUM_SRC), .CTRL_W(CTRL_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready_s), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
        .id_rs_num(id_rs_num), .id_rs_val(id_rs_val), .id_rd_num(id_rd_num),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .ex_valid(ex_valid_s), .ex_pc(ex_pc_s),
        .ex_pc_plus_4(ex_pc_plus_4_s), .ex_rs_num(ex_rs_num_s), .ex_rs_val(ex_rs_val_s),
        .ex_rd_num(ex_rd_num_s), .ex_imm(ex_imm_s), .ex_ctrl(ex_ctrl_s), .bubble_cnt(bubble_cnt_s)
`ifdef ID_WB_BYPASS_EN
        , .wb_we(wb_we), .wb_rd_num(wb_rd_num), .wb_data(wb_data)
`endif
    );

    // ---------------- reference model (what execute should see) ----------------
    logic                    m_valid;
    logic [XLEN-1:0]         m_pc, m_pc4, m_imm;
    logic [RA_W-1:0]         m_rs_num [NUM_SRC];
    logic [XLEN-1:0]         m_rs_val [NUM_SRC];
    logic [RA_W-1:0]         m_rd;
    logic [CTRL_W-1:0]       m_ctrl;
    int                      m_bubbles;

    wire [VW-1:0] dut_vec = {ex_valid, ex_pc, ex_pc_plus_4, ex_rs_num, ex_rs_val,
                             ex_rd_num, ex_imm, ex_ctrl, bubble_cnt};

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_SRC*RA_W-1:0] rn;
        logic [NUM_SRC*XLEN-1:0] rv;
        logic [CNT_W-1:0]        c;
        for (int i = 0; i < NUM_SRC; i++) begin
            rn[i*RA_W +: RA_W] = m_rs_num[i];
            rv[i*XLEN +: XLEN] = m_rs_val[i];
        end
        c = (m_bubbles > 65535) ? 16'hFFFF : CNT_W'(m_bubbles);
        return {m_valid, m_pc, m_pc4, rn, rv, m_rd, m_imm, m_ctrl, c};
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m_bubbles > 3) ? 2'd3 : 2'(m_bubbles);
    endfunction

    // Forwarding rule from the write-back port for a given source register.
    function automatic bit wb_hits(input logic [RA_W-1:0] rs);
`ifdef ID_WB_BYPASS_EN
        return wb_we && (wb_rd_num != 0) && (wb_rd_num == rs);
`else
        return (rs == 1'b0) && 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] wb_value();
`ifdef ID_WB_BYPASS_EN
        return wb_data;
`else
        return '0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (reset) begin
            m_valid = 0; m_pc = 0; m_pc4 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
            m_bubbles = 0;
            for (int i = 0; i < NUM_SRC; i++) begin m_rs_num[i] = 0; m_rs_val[i] = 0; end
        end else if (flush) begin
            m_valid = 0; m_ctrl = 0; m_rd = 0;
            m_bubbles++;
        end else if (stall) begin
            if (m_valid)
                for (int i = 0; i < NUM_SRC; i++)
                    if (wb_hits(m_rs_num[i])) m_rs_val[i] = wb_value();
        end else begin
            m_pc = id_pc; m_pc4 = id_pc_plus_4; m_imm = id_imm;
            for (int i = 0; i < NUM_SRC; i++) begin
                m_rs_num[i] = id_rs_num[i*RA_W +: RA_W];
                m_rs_val[i] = wb_hits(m_rs_num[i]) ? wb_value() : id_rs_val[i*XLEN +: XLEN];
            end
            m_valid = id_valid;
            m_rd    = id_valid ? id_rd_num : '0;
            m_ctrl  = id_valid ? id_ctrl   : '0;
            if (!id_valid) m_bubbles++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand_id();
        id_valid     = 1'($urandom_range(0, 9) < 7);
        id_pc        = $urandom;
        id_pc_plus_4 = id_pc + 4;
        id_rs_num    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        id_rs_val    = {$urandom, $urandom};
        id_rd_num    = 5'($urandom);
        id_imm       = $urandom;
        id_ctrl      = 16'($urandom);
`ifdef ID_WB_BYPASS_EN
        wb_we        = 1'($urandom);
        wb_rd_num    = 5'($urandom_range(0, 7));
        wb_data      = $urandom;
`endif
    endtask

    task automatic idle_ctl();
        reset = 0; stall = 0; flush = 0;
`ifdef ID_WB_BYPASS_EN
        wb_we = 0;
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_rand_id();
        reset = 1; stall = 1; flush = 0;
        tick();
        chk_cnt++;
        if (dut_vec !== '0) $display("FAIL reset_all actual=%h required=0", dut_vec);
        else pass_cnt++;
        chk_cnt++;
        if (bubble_cnt_s !== 2'd0) $display("FAIL reset_cnt2 actual=%0d required=0", bubble_cnt_s);
        else pass_cnt++;
        idle_ctl();
    endtask

    task automatic test_load();
        drive_rand_id();
        idle_ctl();
        id_valid = 1; id_pc = 32'h100; id_pc_plus_4 = 32'h104;
        id_imm = 32'hFFFF_FFF0; id_ctrl = 16'h00A5; id_rd_num = 5'd3;
        tick();
        chk_cnt++;
        if ({ex_valid, ex_pc, ex_imm, ex_ctrl} !== {1'b1, 32'h100, 32'hFFFF_FFF0, 16'h00A5})
            $display("FAIL load_basic actual=%h/%h/%h/%h required=1/100/fffffff0/00a5",
                     ex_valid, ex_pc, ex_imm, ex_ctrl);
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL load_model actual=%h required=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [VW-1:0] frozen;
        frozen = dut_vec;
        for (int k = 0; k < 3; k++) begin
            drive_rand_id();
            idle_ctl();
            stall = 1;
            #1;
            chk_cnt++;
            if (id_ready !== 1'b0) $display("FAIL stall_ready actual=%b required=0", id_ready);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (dut_vec !== frozen) $display("FAIL stall_hold actual=%h required=%h", dut_vec, frozen);
            else pass_cnt++;
        end
        drive_rand_id();
        idle_ctl();
        id_valid = 1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b1) $display("FAIL release_ready actual=%b required=1", id_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dut_vec !== exp_vec() || ex_pc !== id_pc)
            $display("FAIL stall_release actual=%h required=%h", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_flush_stall();
        logic [CNT_W-1:0] c0;
        drive_rand_id();
        idle_ctl();
        id_valid = 1; id_rd_num = 5'd9; id_ctrl = 16'h1234;
        tick();
        c0 = bubble_cnt;
        drive_rand_id();
        idle_ctl();
        flush = 1; stall = 1;
        #1;
        chk_cnt++;
        if (id_ready !== 1'b0) $display("FAIL flush_ready actual=%b required=0", id_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ex_valid, ex_ctrl, ex_rd_num, bubble_cnt} !== {1'b0, 16'h0, 5'h0, c0 + 16'd1})
            $display("FAIL flush_stall actual=%b/%h/%h/%0d required=0/0/0/%0d",
                     ex_valid, ex_ctrl, ex_rd_num, bubble_cnt, c0 + 16'd1);
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL flush_model actual=%h required=%h", dut_vec, exp_vec());
        else pass_cnt++;
        drive_rand_id();
        idle_ctl();
        id_valid = 0;
        tick();
        chk_cnt++;
        if (bubble_cnt !== c0 + 16'd2 || ex_valid !== 1'b0)
            $display("FAIL idle_bubble actual=%0d/%b required=%0d/0", bubble_cnt, ex_valid, c0 + 16'd2);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        idle_ctl(); reset = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            drive_rand_id();
            idle_ctl();
            id_valid = 0;
            tick();
            chk_cnt++;
            if (bubble_cnt_s !== seq[k] || bubble_cnt !== 16'(k + 1))
                $display("FAIL saturate_%0d actual=%0d/%0d required=%0d/%0d",
                         k, bubble_cnt_s, bubble_cnt, seq[k], k + 1);
            else pass_cnt++;
        end
    endtask

`ifdef ID_WB_BYPASS_EN
    task automatic test_bypass();
        logic [VW-1:0] before;
        drive_rand_id();
        idle_ctl();
        id_valid = 1; id_rs_num = {5'd9, 5'd5}; id_rs_val[31:0] = 32'h11;
        wb_we = 1; wb_rd_num = 5'd5; wb_data = 32'h22;
        tick();
        chk_cnt++;
        if (ex_rs_val[31:0] !== 32'h22) $display("FAIL byp_load actual=%h required=22", ex_rs_val[31:0]);
        else pass_cnt++;
        id_rs_num = {5'd9, 5'd0}; wb_rd_num = 5'd0;
        tick();
        chk_cnt++;
        if (ex_rs_val[31:0] !== 32'h11) $display("FAIL byp_r0 actual=%h required=11", ex_rs_val[31:0]);
        else pass_cnt++;
        id_rs_num = {5'd7, 5'd2}; wb_we = 0;
        tick();
        before = dut_vec;
        drive_rand_id();
        idle_ctl();
        stall = 1; wb_we = 1; wb_rd_num = 5'd7; wb_data = 32'h33;
        tick();
        chk_cnt++;
        if (ex_rs_val[63:32] !== 32'h33 ||
            {dut_vec[VW-1:VW-(1+2*XLEN+NUM_SRC*RA_W)], dut_vec[VW-(1+2*XLEN+NUM_SRC*RA_W)-XLEN-1:XLEN*0]} !==
            {before[VW-1:VW-(1+2*XLEN+NUM_SRC*RA_W)], before[VW-(1+2*XLEN+NUM_SRC*RA_W)-XLEN-1:XLEN*0]})
            $display("FAIL byp_stall actual=%h required rs1=33 rest=%h", dut_vec, before);
        else pass_cnt++;
        reset = 1;
        tick();
        chk_cnt++;
        if (dut_vec !== '0) $display("FAIL byp_reset actual=%h required=0", dut_vec);
        else pass_cnt++;
        idle_ctl();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive_rand_id();
            reset = 1'($urandom_range(0, 99) < 3);
            stall = 1'($urandom_range(0, 9) < 3);
            flush = 1'($urandom_range(0, 99) < 15);
            #1;
            chk_cnt++;
            if (id_ready !== ~stall) $display("FAIL rand_ready_%0d actual=%b required=%b", k, id_ready, ~stall);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (dut_vec !== exp_vec() || bubble_cnt_s !== exp_cnt2())
                $display("FAIL rand_%0d actual=%h/%0d required=%h/%0d",
                         k, dut_vec, bubble_cnt_s, exp_vec(), exp_cnt2());
            else pass_cnt++;
        end
    endtask

    initial begin
        idle_ctl();
        drive_rand_id();
        m_bubbles = 0;
        #2;
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_saturate();
`ifdef ID_WB_BYPASS_EN
        test_bypass();
`endif
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
